csr_alu: RTL
============

# csr_alu

CSR execution unit: the initiator side of the core's CSR register-file port. It accepts one CSR instruction at a time from the issuer: CSRRW, CSRRS, CSRRC and their immediate forms. For each instruction it performs the read-modify-write sequence against the CSR block's read/write/error port, and returns the old CSR value to commit with a tag and an error flag. It sits as ALU (4) between the issuer and the CSR assembly.

## Interface
Parameters:
- TAG_W, 6, width of the commit tag carried with each instruction
- XLEN, core_config_pkg::XLEN, data width
- CSR_ADDR_W, core_config_pkg::CSR_ADDR_W, CSR address width (12)

Ports:
- clk  in  1  core clock
- clk_en  in  1  clock enable; low = all state frozen, csr_we forced 0
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk
- flush  in  1  pipeline flush; aborts the in-flight instruction
- in_valid  in  1  issuer presents an instruction
- in_ready  out  1  unit can accept
- in_op  in  3  funct3 of the instruction
- in_addr  in  CSR_ADDR_W  CSR address
- in_rs1_val  in  XLEN  rs1 operand (register forms)
- in_rs1_idx  in  5  rs1 index, or zimm for the immediate forms
- in_tag  in  TAG_W  commit tag
- csr_ra  out  CSR_ADDR_W  CSR read address
- csr_rd  in  XLEN  CSR read data; registered, valid the cycle after csr_ra
- csr_err  in  1  read error (unimplemented address); same timing as csr_rd
- csr_wa  out  CSR_ADDR_W  CSR write address
- csr_we  out  1  CSR write strobe
- csr_wd  out  XLEN  CSR write data
- out_valid  out  1  result available
- out_ready  in  1  commit accepts result
- out_data  out  XLEN  old CSR value; 0 on error
- out_tag  out  TAG_W  tag of the result
- out_err  out  1  illegal instruction or CSR access

## Operation
- States: IDLE, READ, WRITE, RESP.
- Reset values: state IDLE, in_ready 1, out_valid 0, csr_we 0, out_data 0, out_tag 0, out_err 0, csr_ra 0, csr_wa 0, csr_wd 0.
- in_ready = (state == IDLE) && !flush && clk_en.
- Accept (in_valid && in_ready) latches op, addr, rs1_val, rs1_idx and tag.
  - in_op 000 or 100 is illegal: go to RESP with out_err=1 and out_data=0; no CSR access.
  - Any other op goes to READ.
- READ: drive csr_ra = addr. Next state WRITE.
- WRITE: sample csr_rd and csr_err, then compute:
  - src = rs1_val for register forms; src = zero-extended rs1_idx for immediate forms (op[2]=1).
  - new = src (W), old | src (S), old & ~src (C).
  - do_write = 1 for the W forms; for S/C, do_write = (rs1_idx != 0).
  - Read-only violation = do_write && addr[11:10] == 2'b11.
  - csr_we = do_write && !csr_err && !violation && !flush, asserted this cycle only; csr_wa = addr, csr_wd = new.
  - out_data captures old (0 on error); out_err = csr_err || violation. Next state RESP.
- RESP: out_valid=1. Hold out_data, out_tag and out_err stable until out_ready; on the handshake, go to IDLE.
- flush in READ, WRITE or RESP: csr_we=0 and out_valid=0 in that cycle; next state IDLE; the result is discarded.
- flush has priority over out_ready in RESP.
- rst_n low in any state: next state IDLE, all outputs at reset values, no write issued.

## Timing
- Accept on edge N → READ during cycle N+1 → WRITE (csr_we pulse) during N+2 → out_valid from N+3.
- Minimum 4 cycles from accept to next accept. Throughput is one instruction per 4 cycles with out_ready held high.
- csr_we is high for at most one cycle per instruction, never twice.
- Illegal op: out_valid in cycle N+1.
- clk_en low stretches any state indefinitely; csr_we is 0 while clk_en is low.

## Configuration
- CSR_ALU_RO_CHECK_EN defined: the read-only check above is active.
- Without the macro: the violation term is tied to 0. Writes to 0xC00–0xFFF are issued, and the CSR block's own csr_err path is relied on.

## Test plan
- CSRRS to 0x300: old=0x0000_0008, rs1_val=0x80, rs1_idx=5 → csr_we pulse at N+2 with csr_wd=0x88; out_data=0x8, out_err=0 at N+3.
- CSRRCI to 0x300: old=0xFF, zimm=0x0F → csr_wd=0xF0; out_data=0xFF.
- CSRRS x0 to 0xC00 (cycle): no csr_we, out_err=0, out_data=counter value. The same address with CSRRW → no csr_we, out_err=1 (macro on); with the macro off, csr_we=1.
- csr_err=1 on read of 0x7FF → no csr_we, out_err=1, out_data=0.
- flush asserted in WRITE → csr_we stays 0, no out_valid, in_ready=1 the next cycle. The next instruction completes normally.
- out_ready held low 5 cycles in RESP → out_valid, out_data and out_tag stable; in_ready stays 0 until the handshake.

Source files
------------

// File: rtl/csr_alu.sv
// CSR execution unit: runs CSRRW/S/C(I) read-modify-write sequences against the CSR port.
// Optional: define CSR_ALU_RO_CHECK_EN to flag writes to read-only CSRs (addr[11:10] == 2'b11).

package core_config_pkg;
  localparam int XLEN       = 32;
  localparam int CSR_ADDR_W = 12;
endpackage

module csr_alu #(
  parameter int TAG_W      = 6,
  parameter int XLEN       = core_config_pkg::XLEN,
  parameter int CSR_ADDR_W = core_config_pkg::CSR_ADDR_W
) (
  input  logic                  clk,
  input  logic                  clk_en,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_op,
  input  logic [CSR_ADDR_W-1:0] in_addr,
  input  logic [XLEN-1:0]       in_rs1_val,
  input  logic [4:0]            in_rs1_idx,
  input  logic [TAG_W-1:0]      in_tag,
  output logic [CSR_ADDR_W-1:0] csr_ra,
  input  logic [XLEN-1:0]       csr_rd,
  input  logic                  csr_err,
  output logic [CSR_ADDR_W-1:0] csr_wa,
  output logic                  csr_we,
  output logic [XLEN-1:0]       csr_wd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_data,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  out_err
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t                state;
  logic [2:0]            op_q;
  logic [CSR_ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]       rs1_val_q;
  logic [4:0]            rs1_idx_q;

  logic [XLEN-1:0] src;
  logic [XLEN-1:0] new_val;
  logic            do_write;
  logic            violation;
  logic            in_write;

  assign src      = op_q[2] ? {{(XLEN-5){1'b0}}, rs1_idx_q} : rs1_val_q;
  assign do_write = (op_q[1:0] == 2'b01) || (rs1_idx_q != '0);

`ifdef CSR_ALU_RO_CHECK_EN
  assign violation = do_write && (addr_q[CSR_ADDR_W-1 -: 2] == 2'b11);
`else
  assign violation = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    new_val = src;
    case (op_q[1:0])
      2'b10:   new_val = csr_rd | src;
      2'b11:   new_val = csr_rd & ~src;
      default: new_val = src;
    endcase
  end

  // csr_rd only becomes valid during WRITE, so the write strobe must be combinational from it.
  assign in_write  = (state == WRITE) && rst_n;
  assign csr_we    = in_write && clk_en && do_write && !csr_err && !violation && !flush;
  assign csr_wa    = in_write ? addr_q  : '0;
  assign csr_wd    = in_write ? new_val : '0;
  assign out_valid = (state == RESP) && rst_n && !flush;
  assign in_ready  = (state == IDLE) && !flush && clk_en;

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= '0;
      addr_q    <= '0;
      rs1_val_q <= '0;
      rs1_idx_q <= '0;
      csr_ra    <= '0;
      out_data  <= '0;
      out_tag   <= '0;
      out_err   <= 1'b0;
    end else if (clk_en) begin
      if (flush && state != IDLE) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (in_valid && in_ready) begin
              op_q      <= in_op;
              addr_q    <= in_addr;
              rs1_val_q <= in_rs1_val;
              rs1_idx_q <= in_rs1_idx;
              out_tag   <= in_tag;
              if (in_op[1:0] == 2'b00) begin
                state    <= RESP;
                out_data <= '0;
                out_err  <= 1'b1;
              end else begin
                state  <= READ;
                csr_ra <= in_addr;
              end
            end
          end
          READ:  state <= WRITE;
          WRITE: begin
            out_data <= csr_err ? '0 : csr_rd;
            out_err  <= csr_err || violation;
            state    <= RESP;
          end
          RESP: if (out_ready) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
